// File: rtl/if_fetch_unit_if.sv
// Instruction ROM bus between the fetch unit and the ROM.
// The ROM is combinational: rom_inst follows rom_addr in the same cycle.
interface if_fetch_unit_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  modport master (
    output rom_ce,
    output rom_addr,
    input  rom_inst
  );

  modport slave (
    input  rom_ce,
    input  rom_addr,
    output rom_inst
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM and fills the IF/ID register.
// Handles stall, taken-branch, flush and out-of-window fetch faults.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int unsigned INST_MEM_NUM      = 131071,
  parameter int unsigned INST_MEM_NUM_LOG2 = 17,
  parameter logic [31:0] NOP_INST          = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        stall_id,
  input  logic        stall_ex,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  if_fetch_unit_if.master rom,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_fault
);

  localparam int unsigned HI = INST_MEM_NUM_LOG2 + 2;

  typedef enum logic {
    S_BOOT,
    S_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_fault_q, id_fault_d;

  logic        mis_al;
  logic        hi_set;
  logic [31:0] widx;
  logic        fault;

  // Word index split at the ROM decode width; upper bits must be clear.
  assign mis_al = |pc_q[1:0];
  assign hi_set = |pc_q[31:HI];
  assign widx   = 32'(pc_q[HI-1:2]);
  assign fault  = mis_al || hi_set
               || (widx >= INST_MEM_NUM);

  assign rom.rom_ce   = (state_q == S_RUN) && !fault;
  assign rom.rom_addr = pc_q;

  always_comb begin
    state_d    = S_RUN;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_fault_d = id_fault_q;

    if (state_q == S_BOOT) begin
      if (flush) pc_d = new_pc;
      id_pc_d    = '0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      id_fault_d = 1'b0;
    end else begin
      if (flush)            pc_d = new_pc;
      else if (stall_pc)    pc_d = pc_q;
      else if (branch_flag) pc_d = branch_target;
      else                  pc_d = pc_q + 32'd4;

      if (flush || (stall_id && !stall_ex)) begin
        id_pc_d    = '0;
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
        id_fault_d = 1'b0;
      end else if (!stall_id) begin
        id_pc_d    = pc_q;
        id_inst_d  = fault ? NOP_INST
                           : rom.rom_inst;
        id_valid_d = 1'b1;
        id_fault_d = fault;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      id_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_fault_q <= id_fault_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign id_fault = id_fault_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vectors, a reference model of
// the fetch rules checked every cycle, plus literal expectations.
module tb_if_fetch_unit;

  localparam int unsigned MEMN = 131071;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_pc = 1'b0;
  logic        stall_id = 1'b0;
  logic        stall_ex = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_fault;

  if_fetch_unit_if bus();

  always #5 clk = ~clk;

  // ROM content: word i holds i+1
  function automatic logic [31:0] rom_word(logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign bus.rom_inst = rom_word(bus.rom_addr);

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_pc     (stall_pc),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .rom          (bus.master),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .id_fault     (id_fault)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic bit bad(logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= MEMN);
  endfunction

  // Reference model: fetch rules stated directly
  logic [31:0] m_pc;
  bit          m_run;
  logic [31:0] m_idpc, m_idinst;
  bit          m_idv, m_idf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc     <= 32'h0;
      m_run    <= 1'b0;
      m_idpc   <= 32'h0;
      m_idinst <= 32'h0;
      m_idv    <= 1'b0;
      m_idf    <= 1'b0;
    end else if (!m_run) begin
      m_run    <= 1'b1;
      m_pc     <= flush ? new_pc : m_pc;
      m_idpc   <= 32'h0;
      m_idinst <= 32'h0;
      m_idv    <= 1'b0;
      m_idf    <= 1'b0;
    end else begin
      if (flush)            m_pc <= new_pc;
      else if (stall_pc)    m_pc <= m_pc;
      else if (branch_flag) m_pc <= branch_target;
      else                  m_pc <= m_pc + 32'd4;
      if (flush || (stall_id && !stall_ex)) begin
        m_idpc   <= 32'h0;
        m_idinst <= 32'h0;
        m_idv    <= 1'b0;
        m_idf    <= 1'b0;
      end else if (!stall_id) begin
        m_idpc   <= m_pc;
        m_idinst <= bad(m_pc) ? 32'h0 : rom_word(m_pc);
        m_idv    <= 1'b1;
        m_idf    <= bad(m_pc);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_addr", bus.rom_addr, m_pc);
    chk("m_ce", 32'(bus.rom_ce), 32'(m_run && !bad(m_pc)));
    chk("m_idpc", id_pc, m_idpc);
    chk("m_idinst", id_inst, m_idinst);
    chk("m_idv", 32'(id_valid), 32'(m_idv));
    chk("m_idf", 32'(id_fault), 32'(m_idf));
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #12 rst = 1'b1;
    #1;
    chk("boot_ce", 32'(bus.rom_ce), 32'h0);
    chk("boot_addr", bus.rom_addr, 32'h0);
    step();
    chk("t1_addr0", bus.rom_addr, 32'h0);
    chk("t1_ce", 32'(bus.rom_ce), 32'h1);
    chk("t1_v0", 32'(id_valid), 32'h0);
    step();
    chk("t1_addr4", bus.rom_addr, 32'h4);
    chk("t1_inst1", id_inst, 32'h1);
    chk("t1_v1", 32'(id_valid), 32'h1);
    step();
    chk("t1_addr8", bus.rom_addr, 32'h8);
    chk("t1_inst2", id_inst, 32'h2);
    step();
    chk("t1_addrC", bus.rom_addr, 32'hC);
    chk("t1_inst3", id_inst, 32'h3);
    step();
    chk("t2_addr", bus.rom_addr, 32'h10);
    stall_pc = 1'b1;
    stall_id = 1'b1;
    step();
    chk("t2_hold1", bus.rom_addr, 32'h10);
    chk("t2_v1", 32'(id_valid), 32'h0);
    chk("t2_inst1", id_inst, 32'h0);
    step();
    chk("t2_hold2", bus.rom_addr, 32'h10);
    chk("t2_v2", 32'(id_valid), 32'h0);
    stall_pc = 1'b0;
    stall_id = 1'b0;
    step();
    chk("t2_idpc", id_pc, 32'h10);
    chk("t2_addr14", bus.rom_addr, 32'h14);
    branch_flag = 1'b1;
    branch_target = 32'h8;
    step();
    chk("t3_at8", bus.rom_addr, 32'h8);
    branch_target = 32'h40;
    step();
    chk("t3_addr40", bus.rom_addr, 32'h40);
    chk("t3_slot", id_pc, 32'h8);
    branch_flag = 1'b0;
    step();
    chk("t3_idpc40", id_pc, 32'h40);
    chk("t3_inst", id_inst, 32'h11);
    flush = 1'b1;
    new_pc = 32'h20;
    branch_flag = 1'b1;
    branch_target = 32'h80;
    stall_pc = 1'b1;
    step();
    chk("t4_addr20", bus.rom_addr, 32'h20);
    chk("t4_bub", 32'(id_valid), 32'h0);
    chk("t4_idpc", id_pc, 32'h0);
    stall_id = 1'b1;
    stall_ex = 1'b1;
    new_pc = 32'h30;
    step();
    chk("t4_addr30", bus.rom_addr, 32'h30);
    chk("t4_bub2", 32'(id_valid), 32'h0);
    flush = 1'b0;
    branch_flag = 1'b0;
    stall_pc = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    step();
    chk("t4_cap", id_pc, 32'h30);
    chk("t4_inst", id_inst, 32'hD);
    branch_flag = 1'b1;
    branch_target = 32'h42;
    step();
    chk("t5_ce_mis", 32'(bus.rom_ce), 32'h0);
    branch_flag = 1'b0;
    step();
    chk("t5_flt", 32'(id_fault), 32'h1);
    chk("t5_val", 32'(id_valid), 32'h1);
    chk("t5_nop", id_inst, 32'h0);
    chk("t5_adv", bus.rom_addr, 32'h46);
    branch_flag = 1'b1;
    branch_target = 32'h7FFF8;
    step();
    chk("t5_ce_last", 32'(bus.rom_ce), 32'h1);
    branch_flag = 1'b0;
    step();
    chk("t5_ce_end", 32'(bus.rom_ce), 32'h0);
    chk("t5_lastw", id_inst, 32'h1FFFF);
    chk("t5_lastf", 32'(id_fault), 32'h0);
    step();
    chk("t5_endf", 32'(id_fault), 32'h1);
    chk("t5_endpc", id_pc, 32'h7FFFC);
    branch_flag = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_top", bus.rom_addr, 32'hFFFF_FFFC);
    branch_flag = 1'b0;
    step();
    chk("wrap_zero", bus.rom_addr, 32'h0);
    #3 rst = 1'b0;
    #1;
    chk("t6_ce", 32'(bus.rom_ce), 32'h0);
    chk("t6_addr", bus.rom_addr, 32'h0);
    chk("t6_idpc", id_pc, 32'h0);
    chk("t6_inst", id_inst, 32'h0);
    chk("t6_v", 32'(id_valid), 32'h0);
    chk("t6_f", 32'(id_fault), 32'h0);
    #4 rst = 1'b1;
    step();
    chk("t6_boot", 32'(bus.rom_ce), 32'h0);
    step();
    chk("t6_run", 32'(bus.rom_ce), 32'h1);
    chk("t6_v0", 32'(id_valid), 32'h0);
    step();
    chk("t6_first", id_inst, 32'h1);
    stall_id = 1'b1;
    stall_ex = 1'b1;
    step();
    chk("hold_inst", id_inst, 32'h1);
    chk("hold_adv", bus.rom_addr, 32'h8);
    step();
    chk("hold_inst2", id_inst, 32'h1);
    stall_id = 1'b0;
    stall_ex = 1'b0;
    step();
    chk("hold_rel", id_pc, 32'hC);
    stall_pc = 1'b1;
    step();
    chk("spc_pc", id_pc, 32'h10);
    chk("spc_inst", id_inst, 32'h5);
    step();
    chk("spc_rep", id_pc, 32'h10);
    chk("spc_addr", bus.rom_addr, 32'h10);
    stall_pc = 1'b0;
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
